// File: rtl/alu_sequencer.sv
// Three-state instruction sequencer for a 16-register machine: decodes an
// instruction, drives registered operands to an external ALU and writes back.
module alu_sequencer #(
    parameter int BIT_WIDTH    = 16,
    parameter int OPCODE_WIDTH = 8,
    parameter int FLAG_WIDTH   = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [15:0]             instr,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    output logic [OPCODE_WIDTH-1:0] alu_opcode,
    output logic [BIT_WIDTH-1:0]    alu_rdest,
    output logic [BIT_WIDTH-1:0]    alu_rsrc_imm,
    input  logic [BIT_WIDTH-1:0]    alu_result,
    input  logic [FLAG_WIDTH-1:0]   alu_flags,
    output logic [FLAG_WIDTH-1:0]   psr,
    output logic                    done,
    output logic                    illegal,
    input  logic [3:0]              dbg_addr,
    output logic [BIT_WIDTH-1:0]    dbg_data
);

    // Flag bit order is {C,L,F,Z,N}
    localparam logic [FLAG_WIDTH-1:0] MASK_FZN = FLAG_WIDTH'(5'b00111);
    localparam logic [FLAG_WIDTH-1:0] MASK_CLZ = FLAG_WIDTH'(5'b11010);
    localparam logic [FLAG_WIDTH-1:0] MASK_ZN  = FLAG_WIDTH'(5'b00011);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [BIT_WIDTH-1:0] regs [16];

    logic [3:0] hi;
    logic [3:0] rd;
    logic [3:0] ext;
    logic [3:0] rs;
    logic       accept;

    logic [OPCODE_WIDTH-1:0] dec_opcode;
    logic [BIT_WIDTH-1:0]    dec_src;
    logic [FLAG_WIDTH-1:0]   dec_mask;
    logic                    dec_wen;
    logic                    dec_illegal;

    logic [3:0]            rd_q;
    logic [FLAG_WIDTH-1:0] mask_q;
    logic                  wen_q;
    logic                  illegal_q;

    assign hi  = instr[15:12];
    assign rd  = instr[11:8];
    assign ext = instr[7:4];
    assign rs  = instr[3:0];

    assign instr_ready = (state == IDLE);
    assign accept      = instr_valid && instr_ready;
    assign done        = (state == WB);
    assign illegal     = (state == WB) && illegal_q;
    assign dbg_data    = regs[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = EXEC;
            EXEC:    next_state = WB;
            WB:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Decode selects the source operand and which psr bits the writeback may touch
    always_comb begin
        dec_opcode  = OPCODE_WIDTH'({hi, ext});
        dec_src     = '0;
        dec_mask    = '0;
        dec_wen     = 1'b0;
        dec_illegal = 1'b0;
        case (hi)
            4'h0: begin
                dec_src = regs[rs];
                case (ext)
                    4'h0: dec_wen = 1'b0;
                    4'h1, 4'h2, 4'h3, 4'h4: begin
                        dec_mask = MASK_ZN;
                        dec_wen  = 1'b1;
                    end
                    4'h5, 4'h7, 4'h9: begin
                        dec_mask = MASK_FZN;
                        dec_wen  = 1'b1;
                    end
                    4'h6: begin
                        dec_mask = MASK_CLZ;
                        dec_wen  = 1'b1;
                    end
                    4'hB: dec_mask = MASK_ZN;
                    default: dec_illegal = 1'b1;
                endcase
            end
            4'h5, 4'h7, 4'h9: begin
                dec_src  = {{(BIT_WIDTH-8){instr[7]}}, instr[7:0]};
                dec_mask = MASK_FZN;
                dec_wen  = 1'b1;
            end
            4'h6: begin
                dec_src  = {{(BIT_WIDTH-8){instr[7]}}, instr[7:0]};
                dec_mask = MASK_CLZ;
                dec_wen  = 1'b1;
            end
            4'hB: begin
                dec_src  = {{(BIT_WIDTH-8){instr[7]}}, instr[7:0]};
                dec_mask = MASK_ZN;
            end
            4'h8: begin
                if (ext == 4'h4 || ext == 4'h6) begin
                    dec_src = regs[rs];
                end else begin
                    dec_src = {{(BIT_WIDTH-4){1'b0}}, instr[3:0]};
                end
                dec_mask = MASK_ZN;
                dec_wen  = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Operands are captured at accept and held; writeback commits on the WB edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
            psr          <= '0;
            alu_opcode   <= '0;
            alu_rdest    <= '0;
            alu_rsrc_imm <= '0;
            rd_q         <= '0;
            mask_q       <= '0;
            wen_q        <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            if (accept) begin
                alu_opcode   <= dec_opcode;
                alu_rdest    <= regs[rd];
                alu_rsrc_imm <= dec_src;
                rd_q         <= rd;
                mask_q       <= dec_mask;
                wen_q        <= dec_wen;
                illegal_q    <= dec_illegal;
            end
            if (state == WB) begin
                if (wen_q) begin
                    regs[rd_q] <= alu_result;
                end
                psr <= (psr & ~mask_q) | (alu_flags & mask_q);
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small reference ALU closing the loop.
module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  alu_opcode;
    logic [15:0] alu_rdest;
    logic [15:0] alu_rsrc_imm;
    logic [15:0] alu_result;
    logic [4:0]  alu_flags;
    logic [4:0]  psr;
    logic        done;
    logic        illegal;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int compared;
    int mismatched;

    logic [15:0] shadow [16];

    typedef struct {
        logic [15:0] instr;
        logic        chk_alu;
        logic [7:0]  exp_op;
        logic [15:0] exp_src;
        logic        exp_ill;
        logic [15:0] exp_val;
        logic [4:0]  exp_psr;
    } vec_t;

    vec_t vecs [14];

    alu_sequencer #(
        .BIT_WIDTH(16),
        .OPCODE_WIDTH(8),
        .FLAG_WIDTH(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .instr(instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .alu_opcode(alu_opcode),
        .alu_rdest(alu_rdest),
        .alu_rsrc_imm(alu_rsrc_imm),
        .alu_result(alu_result),
        .alu_flags(alu_flags),
        .psr(psr),
        .done(done),
        .illegal(illegal),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: flags {C,L,F,Z,N}, compare sets Z on equality
    always_comb begin
        logic [3:0]  code;
        logic [16:0] wide;
        logic        c_f;
        logic        l_f;
        logic        f_f;
        logic        z_f;
        logic        n_f;
        code = (alu_opcode[7:4] == 4'h0) ? alu_opcode[3:0] : alu_opcode[7:4];
        wide = '0;
        c_f  = 1'b0;
        l_f  = 1'b0;
        f_f  = 1'b0;
        alu_result = '0;
        if (alu_opcode[7:4] == 4'h8) begin
            if (alu_opcode[3:0] == 4'h0 || alu_opcode[3:0] == 4'h4) begin
                alu_result = alu_rdest << alu_rsrc_imm[3:0];
            end else begin
                alu_result = alu_rdest >> alu_rsrc_imm[3:0];
            end
        end else begin
            case (code)
                4'h1: alu_result = alu_rdest & alu_rsrc_imm;
                4'h2: alu_result = alu_rdest | alu_rsrc_imm;
                4'h3: alu_result = alu_rdest ^ alu_rsrc_imm;
                4'h4: alu_result = ~alu_rsrc_imm;
                4'h5, 4'h6, 4'h7: begin
                    wide = {1'b0, alu_rdest} + {1'b0, alu_rsrc_imm};
                    alu_result = wide[15:0];
                    c_f = wide[16];
                    f_f = (alu_rdest[15] == alu_rsrc_imm[15]) && (wide[15] != alu_rdest[15]);
                end
                4'h9: begin
                    alu_result = alu_rdest - alu_rsrc_imm;
                    f_f = (alu_rdest[15] != alu_rsrc_imm[15]) && (alu_result[15] != alu_rdest[15]);
                end
                default: alu_result = '0;
            endcase
        end
        if (alu_opcode[7:4] != 4'h8 && code == 4'hB) begin
            z_f = (alu_rdest == alu_rsrc_imm);
            n_f = ($signed(alu_rdest) < $signed(alu_rsrc_imm));
            l_f = (alu_rdest < alu_rsrc_imm);
        end else begin
            z_f = (alu_result == 16'h0000);
            n_f = alu_result[15];
        end
        alu_flags = {c_f, l_f, f_f, z_f, n_f};
    end

    task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One instruction through accept, EXEC, WB and back to IDLE
    task automatic run_vec(input vec_t v);
        logic [3:0] rd;
        rd = v.instr[11:8];
        dbg_addr = rd;
        @(negedge clk);
        check_value("ready_idle", 32'(instr_ready), 32'd1);
        instr = v.instr;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        check_value("ready_exec", 32'(instr_ready), 32'd0);
        check_value("done_exec", 32'(done), 32'd0);
        if (v.chk_alu) begin
            check_value("alu_opcode", 32'(alu_opcode), 32'(v.exp_op));
            check_value("alu_rsrc_imm", 32'(alu_rsrc_imm), 32'(v.exp_src));
            check_value("alu_rdest", 32'(alu_rdest), 32'(shadow[rd]));
        end
        @(negedge clk);
        check_value("ready_wb", 32'(instr_ready), 32'd0);
        check_value("done_wb", 32'(done), 32'd1);
        check_value("illegal_wb", 32'(illegal), 32'(v.exp_ill));
        check_value("dbg_old_in_wb", 32'(dbg_data), 32'(shadow[rd]));
        @(negedge clk);
        check_value("ready_after", 32'(instr_ready), 32'd1);
        check_value("done_after", 32'(done), 32'd0);
        check_value("reg_after", 32'(dbg_data), 32'(v.exp_val));
        check_value("psr_after", 32'(psr), 32'(v.exp_psr));
        shadow[rd] = v.exp_val;
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        rst_n       = 1'b0;
        instr       = '0;
        instr_valid = 1'b0;
        dbg_addr    = '0;
        for (int i = 0; i < 16; i++) shadow[i] = '0;

        //          instr     chk   op     src       ill   value     psr
        vecs[0]  = '{16'h5105, 1'b1, 8'h50, 16'h0005, 1'b0, 16'h0005, 5'h00};
        vecs[1]  = '{16'h52FF, 1'b1, 8'h5F, 16'hFFFF, 1'b0, 16'hFFFF, 5'h01};
        vecs[2]  = '{16'h0251, 1'b1, 8'h05, 16'h0005, 1'b0, 16'h0004, 5'h00};
        vecs[3]  = '{16'h51FF, 1'b1, 8'h5F, 16'hFFFF, 1'b0, 16'h0004, 5'h00};
        vecs[4]  = '{16'h02B1, 1'b1, 8'h0B, 16'h0004, 1'b0, 16'h0004, 5'h02};
        vecs[5]  = '{16'hF123, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h0004, 5'h02};
        vecs[6]  = '{16'h0000, 1'b1, 8'h00, 16'h0000, 1'b0, 16'h0000, 5'h02};
        vecs[7]  = '{16'h62FF, 1'b1, 8'h6F, 16'hFFFF, 1'b0, 16'h0003, 5'h10};
        vecs[8]  = '{16'h0292, 1'b1, 8'h09, 16'h0003, 1'b0, 16'h0000, 5'h12};
        vecs[9]  = '{16'h5301, 1'b1, 8'h50, 16'h0001, 1'b0, 16'h0001, 5'h10};
        vecs[10] = '{16'h8303, 1'b1, 8'h80, 16'h0003, 1'b0, 16'h0008, 5'h10};
        vecs[11] = '{16'h8343, 1'b1, 8'h84, 16'h0008, 1'b0, 16'h0800, 5'h10};
        vecs[12] = '{16'h0113, 1'b1, 8'h01, 16'h0800, 1'b0, 16'h0000, 5'h12};
        vecs[13] = '{16'h0181, 1'b0, 8'h00, 16'h0000, 1'b1, 16'h0000, 5'h12};

        repeat (3) @(negedge clk);
        check_value("rst_ready", 32'(instr_ready), 32'd1);
        check_value("rst_done", 32'(done), 32'd0);
        check_value("rst_illegal", 32'(illegal), 32'd0);
        check_value("rst_psr", 32'(psr), 32'd0);
        check_value("rst_opcode", 32'(alu_opcode), 32'd0);
        check_value("rst_r0", 32'(dbg_data), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i]);
        end

        // Reset during EXEC with valid still asserted aborts the instruction
        dbg_addr = 4'd3;
        @(negedge clk);
        instr = 16'h5107;
        instr_valid = 1'b1;
        @(negedge clk);
        check_value("abort_ready_exec", 32'(instr_ready), 32'd0);
        check_value("abort_opcode", 32'(alu_opcode), 32'h50);
        check_value("abort_src", 32'(alu_rsrc_imm), 32'h0007);
        rst_n = 1'b0;
        #1;
        check_value("abort_done", 32'(done), 32'd0);
        check_value("abort_psr", 32'(psr), 32'd0);
        check_value("abort_r3", 32'(dbg_data), 32'd0);
        check_value("abort_opcode_rst", 32'(alu_opcode), 32'd0);
        instr_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_value("abort_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        check_value("post_rst_ready", 32'(instr_ready), 32'd1);
        dbg_addr = 4'd1;
        @(negedge clk);
        check_value("post_rst_ready2", 32'(instr_ready), 32'd1);
        check_value("post_rst_done", 32'(done), 32'd0);
        check_value("post_rst_r1", 32'(dbg_data), 32'd0);

        // A held instruction is not re-captured while EXEC and WB are in progress
        instr = 16'h5107;
        instr_valid = 1'b1;
        @(negedge clk);
        instr = 16'h5102;
        @(negedge clk);
        check_value("hold_done", 32'(done), 32'd1);
        check_value("hold_src", 32'(alu_rsrc_imm), 32'h0007);
        instr_valid = 1'b0;
        @(negedge clk);
        check_value("hold_r1", 32'(dbg_data), 32'h0007);
        check_value("hold_ready", 32'(instr_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
